laser_pool: RTL and testbench

LASER_POOL -- requirements
Module: laser_pool

---
 rtl/space_pkg.sv | 10 +
 rtl/laser_pool_if.sv | 18 +
 rtl/laser_slot.sv | 58 +++++
 rtl/laser_pool.sv | 53 +++++
 tb/tb_laser_pool.sv | 131 +++++++++++++
 5 files changed

// File: rtl/space_pkg.sv
// space_pkg: colour codes, screen and ship geometry shared by the laser pool.
package space_pkg;
  localparam logic [2:0] BACKGROUND = 3'd0;
  localparam logic [2:0] LASER = 3'd6;
  localparam int SCREEN_WIDTH = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int SHIP_HEIGHT = 30;
  localparam int V_OFFSET = 10;
  typedef enum logic {IDLE, FLYING} slot_state_t;
endpackage

// File: rtl/laser_pool_if.sv
// laser_pool_if: control, VGA position and slot status bundle of the laser pool.
interface laser_pool_if #(parameter int N_LASERS = 4);
  logic enable;
  logic fire;
  logic [N_LASERS-1:0] hitMask;
  logic [9:0] gunPosition;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [10*N_LASERS-1:0] xLasers;
  logic [10*N_LASERS-1:0] yLasers;
  logic [N_LASERS-1:0] aliveMask;
  logic [2:0] colorLaser;
  logic poolFull;
  modport master(output enable, fire, hitMask, gunPosition, hPos, vPos,
                 input xLasers, yLasers, aliveMask, colorLaser, poolFull);
  modport slave(input enable, fire, hitMask, gunPosition, hPos, vPos,
                output xLasers, yLasers, aliveMask, colorLaser, poolFull);
endinterface

// File: rtl/laser_slot.sv
// laser_slot: one laser's flight state, upward motion and pixel disc test.
module laser_slot #(
  parameter int RADIUS = 4,
  parameter int STEP_MOTION = 1,
  parameter int SCREEN_WIDTH = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int Y_LAUNCH = 436
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       launch,
  input  logic       hit,
  input  logic [9:0] gun,
  input  logic [9:0] h,
  input  logic [9:0] v,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       alive,
  output logic       in_disc
);
  import space_pkg::*;
  localparam logic [9:0] X_IDLE = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] Y_IDLE = 10'(SCREEN_HEIGHT - 1);
  localparam logic [9:0] Y0 = 10'(Y_LAUNCH);
  localparam logic [9:0] STEP = 10'(STEP_MOTION);
  localparam logic [21:0] RR = 22'(RADIUS * RADIUS);
  slot_state_t st;
  logic signed [10:0] dx, dy;
  logic [21:0] d2;
  assign alive = st == FLYING;
  // Signed 11-bit deltas keep far-edge pixels from wrapping into a hit.
  always_comb begin
    dx = $signed({1'b0, h} - {1'b0, x});
    dy = $signed({1'b0, v} - {1'b0, y});
    d2 = $unsigned(22'(dx) * 22'(dx)) + $unsigned(22'(dy) * 22'(dy));
    in_disc = alive && d2 <= RR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      x <= X_IDLE;
      y <= Y_IDLE;
    end else if (enable) begin
      if (st == IDLE && launch) begin
        st <= FLYING;
        x <= gun;
        y <= Y0;
      end else if (st == FLYING && (hit || y < STEP)) begin
        st <= IDLE;
        x <= X_IDLE;
        y <= Y_IDLE;
      end else if (st == FLYING) begin
        y <= y - STEP;
      end
    end
  end
endmodule

// File: rtl/laser_pool.sv
// laser_pool: allocates laser slots on fire with a cooldown and ORs their pixels.
module laser_pool #(
  parameter int N_LASERS = 4,
  parameter int RADIUS = 4,
  parameter int STEP_MOTION = 1,
  parameter int COOLDOWN = 20,
  parameter int SCREEN_WIDTH = space_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = space_pkg::SCREEN_HEIGHT,
  parameter int SHIP_HEIGHT = space_pkg::SHIP_HEIGHT,
  parameter int V_OFFSET = space_pkg::V_OFFSET
) (
  input logic clk,
  input logic reset,
  laser_pool_if.slave bus
);
  import space_pkg::*;
  localparam int Y_LAUNCH = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - RADIUS;
  logic [15:0] cd;
  logic [N_LASERS-1:0] launch, alive, in_disc;
  logic [10*N_LASERS-1:0] xl, yl;
  // Allocation looks only at slots idle before this tick, so a slot freed now waits a tick.
  always_comb begin
    launch = '0;
    for (int i = N_LASERS - 1; i >= 0; i--)
      if (!alive[i]) launch = N_LASERS'(1) << i;
    launch = (bus.fire && cd == '0) ? launch : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) cd <= '0;
    else if (enable_tick()) cd <= |launch ? 16'(COOLDOWN) : (cd != '0 ? cd - 16'd1 : cd);
  end
  always_ff @(posedge clk) begin
    if (reset) bus.colorLaser <= BACKGROUND;
    else bus.colorLaser <= |in_disc ? LASER : BACKGROUND;
  end
  function automatic logic enable_tick();
    return bus.enable;
  endfunction
  for (genvar i = 0; i < N_LASERS; i++) begin : g_slot
    laser_slot #(
      .RADIUS(RADIUS), .STEP_MOTION(STEP_MOTION), .SCREEN_WIDTH(SCREEN_WIDTH),
      .SCREEN_HEIGHT(SCREEN_HEIGHT), .Y_LAUNCH(Y_LAUNCH)
    ) u_slot (
      .clk(clk), .rst(reset), .enable(bus.enable), .launch(launch[i]),
      .hit(bus.hitMask[i]), .gun(bus.gunPosition), .h(bus.hPos), .v(bus.vPos),
      .x(xl[10*i +: 10]), .y(yl[10*i +: 10]), .alive(alive[i]), .in_disc(in_disc[i])
    );
  end
  assign bus.xLasers = xl;
  assign bus.yLasers = yl;
  assign bus.aliveMask = alive;
  assign bus.poolFull = &alive;
endmodule

// File: tb/tb_laser_pool.sv
// tb_laser_pool: directed scenarios plus random traffic against a slot-list reference model.
module tb_laser_pool;
  localparam int N = 4, R = 4, STEP = 1, CD = 20, YL = 436;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  laser_pool_if #(.N_LASERS(N)) bus();
  laser_pool #(.N_LASERS(N)) dut(.clk(clk), .reset(reset), .bus(bus));
  int total = 0, bad = 0;
  int m_alive[N], m_x[N], m_y[N], m_cd;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(bit r, bit en, bit fr, logic [N-1:0] hm, int gun, int h, int v);
    int ec, l;
    logic [10*N-1:0] ex, ey;
    logic [N-1:0] ea;
    reset = r; bus.enable = en; bus.fire = fr; bus.hitMask = hm;
    bus.gunPosition = 10'(gun); bus.hPos = 10'(h); bus.vPos = 10'(v);
    ec = 0;
    for (int i = 0; i < N; i++)
      if (m_alive[i] != 0 && (h - m_x[i]) * (h - m_x[i]) + (v - m_y[i]) * (v - m_y[i]) <= R * R) ec = 6;
    if (r) ec = 0;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) m_alive[i] = 0;
      m_cd = 0;
    end else if (en) begin
      l = -1;
      if (fr && m_cd == 0)
        for (int i = N - 1; i >= 0; i--) if (m_alive[i] == 0) l = i;
      for (int i = 0; i < N; i++)
        if (m_alive[i] != 0) begin
          if (hm[i] || m_y[i] < STEP) m_alive[i] = 0;
          else m_y[i] -= STEP;
        end
      if (l >= 0) begin
        m_alive[l] = 1; m_x[l] = gun; m_y[l] = YL; m_cd = CD;
      end else if (m_cd > 0) m_cd--;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      ea[i] = m_alive[i] != 0;
      ex[10*i +: 10] = ea[i] ? 10'(m_x[i]) : 10'd639;
      ey[10*i +: 10] = ea[i] ? 10'(m_y[i]) : 10'd479;
    end
    check("alive", bus.aliveMask, ea);
    check("x", bus.xLasers, ex);
    check("y", bus.yLasers, ey);
    check("full", bus.poolFull, &ea);
    check("color", bus.colorLaser, ec);
  endtask

  task automatic ticks(int n, bit fr, int gun);
    repeat (n) step(0, 1, fr, '0, gun, 0, 0);
  endtask

  initial begin
    int h, v, k;
    step(1, 0, 0, '0, 0, 0, 0);
    step(1, 1, 1, '1, 5, 0, 0);
    check("rst_y", bus.yLasers, {N{10'd479}});
    check("rst_x", bus.xLasers, {N{10'd639}});
    step(0, 1, 1, '0, 100, 0, 0);
    check("launch_x", bus.xLasers[9:0], 100);
    check("launch_y", bus.yLasers[9:0], 436);
    ticks(10, 0, 0);
    check("y_after10", bus.yLasers[9:0], 426);
    step(1, 0, 0, '0, 0, 0, 0);
    for (int t = 0; t < 85; t++) begin
      step(0, 1, 1, '0, 50 + t, 0, 0);
      if (t == 21) check("launch21", bus.aliveMask, 4'b0011);
      if (t == 62) check("full_62", bus.poolFull, 0);
      if (t == 63) check("full_63", bus.poolFull, 1);
    end
    check("dropped84", bus.xLasers[39:30], 113);
    step(0, 1, 1, 4'b0010, 300, 0, 0);
    check("hit_no_relaunch", bus.aliveMask, 4'b1101);
    step(0, 1, 1, '0, 301, 0, 0);
    check("relaunch", bus.xLasers[19:10], 301);
    step(1, 0, 0, '0, 0, 0, 0);
    step(0, 1, 1, '0, 7, 0, 0);
    ticks(436, 0, 0);
    check("top_y0", bus.yLasers[9:0], 0);
    step(0, 1, 0, '0, 0, 0, 0);
    check("exit_alive", bus.aliveMask[0], 0);
    check("exit_y", bus.yLasers[9:0], 479);
    step(1, 0, 0, '0, 0, 0, 0);
    step(0, 1, 1, '0, 100, 0, 0);
    ticks(236, 0, 0);
    step(0, 0, 0, '0, 0, 104, 200);
    check("disc_in", bus.colorLaser, 6);
    step(0, 0, 0, '0, 0, 103, 203);
    check("disc_out", bus.colorLaser, 0);
    step(1, 0, 0, '0, 0, 0, 0);
    step(0, 1, 1, '0, 2, 0, 0);
    ticks(236, 0, 0);
    step(0, 0, 0, '0, 0, 2, 200);
    check("edge_in", bus.colorLaser, 6);
    step(0, 0, 0, '0, 0, 1020, 200);
    check("edge_wrap", bus.colorLaser, 0);
    step(1, 0, 0, '0, 0, 0, 0);
    ticks(43, 1, 200);
    check("three_fly", bus.aliveMask, 4'b0111);
    step(1, 0, 1, '0, 0, 0, 0);
    check("rst_en0", bus.aliveMask, 0);
    check("rst_en0_x", bus.xLasers, {N{10'd639}});
    repeat (3000) begin
      k = int'($urandom_range(N - 1));
      if (m_alive[k] != 0 && $urandom_range(1) == 1) begin
        h = m_x[k] + int'($urandom_range(10)) - 5;
        v = m_y[k] + int'($urandom_range(10)) - 5;
      end else begin
        h = int'($urandom_range(1023));
        v = int'($urandom_range(1023));
      end
      h = h < 0 ? 0 : (h > 1023 ? 1023 : h);
      v = v < 0 ? 0 : (v > 1023 ? 1023 : v);
      step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
           {$urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0},
           int'($urandom_range(639)), h, v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
